// File: rtl/rec_pkg.sv
// rec_pkg: shared record types for the record FIFO.
//   byte_t : 8-bit field type
//   pair_t : packed pair {a, b}
//   rec_t  : packed record {a, b, t, ps}, MSB first, REC_W bits wide
//   SWAP_NONE / SWAP_PS : output pair-transform selectors
package rec_pkg;

  typedef logic [7:0] byte_t;

  typedef struct packed {
    byte_t a;
    byte_t b;
  } pair_t;

  typedef struct packed {
    logic        a;
    logic [7:0]  b;
    byte_t       t;
    pair_t       ps;
  } rec_t;

  localparam int REC_W     = 33;
  localparam int SWAP_NONE = 0;
  localparam int SWAP_PS   = 1;

  // Exchange the two halves of a pair.
  function automatic pair_t swap_pair(input pair_t p);
    pair_t r;
    r.a = p.b;
    r.b = p.a;
    return r;
  endfunction

endpackage

// File: rtl/rec_fifo_mem.sv
// rec_fifo_mem: DEPTH x W raw storage for the record FIFO.
//   clk_i      : clock
//   wr_en_i    : write strobe, sampled on the rising edge
//   wr_addr_i  : write address
//   wr_data_i  : write data
//   rd_addr_i  : read address (asynchronous read)
//   rd_data_o  : read data
// Contents are deliberately not reset; the FIFO pointers define validity.
module rec_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic                     clk_i,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [W-1:0]             wr_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [W-1:0]             rd_data_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Synchronous write port.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/rec_fifo.sv
// rec_fifo: first-word-fall-through FIFO of rec_t records.
//   clk       : clock
//   rst_n     : synchronous active-low reset
//   in_valid  / in_ready  / in_rec  : write handshake and record
//   out_valid / out_ready / out_rec : read handshake and transformed head
//   count     : current occupancy
//   overflow  : sticky, set when a record is offered while full
// Parameters: DEPTH (power of two), SWAP (exchange ps.a/ps.b on output),
// FILL_T (force output t to 8'h55).
module rec_fifo
  import rec_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SWAP   = 0,
  parameter int FILL_T = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  rec_t                       in_rec,
  output logic                       out_valid,
  input  logic                       out_ready,
  output rec_t                       out_rec,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic             push_s;
  logic             pop_s;
  logic [REC_W-1:0] rd_data_s;
  rec_t             head_s;
  rec_t             out_rec_s;

  // Flags are pure decodes of the registered count.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != {CW{1'b0}});
  assign push_s    = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (in_valid & ~in_ready);
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // A push coinciding with reset must not touch storage either.
  rec_fifo_mem #(
    .DEPTH(DEPTH),
    .W    (REC_W)
  ) u_mem (
    .clk_i     (clk),
    .wr_en_i   (push_s & rst_n),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (in_rec),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data_s)
  );

  assign head_s = rec_t'(rd_data_s);

  // Output transform; an empty FIFO presents all zeros instead of stale memory.
  always_comb begin
    out_rec_s = head_s;
    if (SWAP == SWAP_PS) begin
      out_rec_s.ps = swap_pair(head_s.ps);
    end else begin
      out_rec_s.ps = head_s.ps;
    end
    if (FILL_T != 0) begin
      out_rec_s.t = 8'h55;
    end else begin
      out_rec_s.t = head_s.t;
    end
    if (!out_valid) begin
      out_rec_s = '0;
    end else begin
      out_rec_s = out_rec_s;
    end
  end

  assign out_rec  = out_rec_s;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_rec_fifo.sv
module tb_rec_fifo;
  import rec_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  rec_t in_rec = '0;

  logic in_ready0, out_valid0, overflow0;
  logic in_ready1, out_valid1, overflow1;
  rec_t out_rec0, out_rec1;
  logic [CW-1:0] count0, count1;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  rec_t exp_q[$];
  int   m_count = 0;
  logic m_ovf   = 1'b0;

  always #5 clk = ~clk;

  rec_fifo #(.DEPTH(DEPTH), .SWAP(0), .FILL_T(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_rec(in_rec), .out_valid(out_valid0), .out_ready(out_ready),
    .out_rec(out_rec0), .count(count0), .overflow(overflow0));

  rec_fifo #(.DEPTH(DEPTH), .SWAP(1), .FILL_T(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_rec(in_rec), .out_valid(out_valid1), .out_ready(out_ready),
    .out_rec(out_rec1), .count(count1), .overflow(overflow1));

  function automatic rec_t xform(input rec_t r, input bit sw, input bit fill);
    rec_t o;
    o = r;
    if (sw) begin
      o.ps.a = r.ps.b;
      o.ps.b = r.ps.a;
    end
    if (fill) o.t = 8'h55;
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: applies FIFO rules on each edge using the pre-edge inputs.
  always @(posedge clk) begin
    bit push, pop;
    if (!rst_n) begin
      exp_q.delete();
      m_count = 0;
      m_ovf   = 1'b0;
    end else begin
      push = in_valid && (m_count < DEPTH);
      pop  = out_ready && (m_count > 0);
      if (in_valid && m_count == DEPTH) m_ovf = 1'b1;
      m_count = m_count + (push ? 1 : 0) - (pop ? 1 : 0);
      if (push) exp_q.push_back(in_rec);
    end
  end

  // Monitor: compares status every cycle and the head whenever it is taken.
  always @(negedge clk) begin
    rec_t h;
    chk("count0", 64'(count0), 64'(m_count));
    chk("count1", 64'(count1), 64'(m_count));
    chk("in_ready", 64'({in_ready0, in_ready1}), m_count != DEPTH ? 64'h3 : 64'h0);
    chk("out_valid", 64'({out_valid0, out_valid1}), m_count != 0 ? 64'h3 : 64'h0);
    chk("overflow", 64'({overflow0, overflow1}), m_ovf ? 64'h3 : 64'h0);
    if (m_count == 0) begin
      chk("empty_rec0", 64'(out_rec0), 64'h0);
      chk("empty_rec1", 64'(out_rec1), 64'h0);
    end
    if (out_valid0 && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_underrun", 64'h1, 64'h0);
      end else begin
        h = exp_q.pop_front();
        chk("out_rec0", 64'(out_rec0), 64'(xform(h, 1'b0, 1'b0)));
        chk("out_rec1", 64'(out_rec1), 64'(xform(h, 1'b1, 1'b1)));
      end
    end
  end

  task automatic step(input logic iv, input logic ordy, input rec_t r);
    in_valid  = iv;
    out_ready = ordy;
    in_rec    = r;
    @(posedge clk);
    #1;
  endtask

  function automatic rec_t mk(input logic a, input logic [7:0] b, input logic [7:0] t,
                              input logic [7:0] pa, input logic [7:0] pb);
    rec_t r;
    r.a = a; r.b = b; r.t = t; r.ps.a = pa; r.ps.b = pb;
    return r;
  endfunction

  initial begin
    rec_t r;
    int   bval;
    // Reset and idle
    rst_n = 1'b0;
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, '0);

    // Single records through both transforms
    step(1'b1, 1'b0, mk(1'b1, 8'hFF, 8'h55, 8'hAA, 8'h55));
    step(1'b0, 1'b1, '0);
    step(1'b1, 1'b0, mk(1'b1, 8'h12, 8'h00, 8'hAA, 8'h55));
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);

    // Overfill then drain
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, mk(1'b0, 8'(i), 8'(i), 8'h00, 8'h00));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, '0);

    // Sustained push+pop from count=2, pointers wrap repeatedly
    bval = 16;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, mk(1'b1, 8'(bval), 8'hC3, 8'h01, 8'h02));
      bval++;
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, mk(1'b1, 8'(bval), 8'hC3, 8'(i), 8'(~i)));
      bval++;
    end
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);

    // Reset mid-burst at count=3, with a push in the reset cycle
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, mk(1'b0, 8'h30 + 8'(i), 8'h11, 8'h22, 8'h33));
    rst_n = 1'b0;
    step(1'b1, 1'b0, mk(1'b1, 8'hEE, 8'hEE, 8'hEE, 8'hEE));
    rst_n = 1'b1;
    step(1'b1, 1'b0, mk(1'b1, 8'h77, 8'h66, 8'h44, 8'h99));
    step(1'b0, 1'b1, '0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      r = rec_t'({$urandom, $urandom});
      rst_n = ($urandom_range(0, 59) != 0);
      step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0), r);
    end
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b1, '0);

    chk("final_drained", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rec_fifo.md
# rec_fifo

Parametrised first-in first-out buffer for the packed record type `rec_pkg::rec_t`, the record shape used across the packed-struct tests. Records enter and leave on valid/ready handshakes, are stored whole as packed vectors, and can be field-transformed on the way out. It is the sequential successor of the flat struct-assignment checks: the same nested packed record, now buffered with depth, occupancy, overflow and output-mode controls.

## Interface
Parameters:
- `DEPTH`, 4: number of record entries; power of two, 2..256.
- `SWAP`, 0: 0 passes `ps` unchanged; 1 exchanges `ps.a` and `ps.b` on the output.
- `FILL_T`, 0: 0 passes `t` unchanged; 1 forces output `t` to 8'h55.

Ports:
- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `in_valid`, input, 1: `in_rec` is valid.
- `in_ready`, output, 1: the FIFO accepts a record this cycle.
- `in_rec`, input, `rec_t` (33 bits): incoming record.
- `out_valid`, output, 1: `out_rec` holds the head record.
- `out_ready`, input, 1: the consumer takes the head this cycle.
- `out_rec`, output, `rec_t`: head record after the SWAP/FILL_T transform.
- `count`, output, `$clog2(DEPTH+1)`: current occupancy.
- `overflow`, output, 1: sticky flag; set when `in_valid` is high while `in_ready` is low.

## Operation
- push = `in_valid & in_ready`. pop = `out_valid & out_ready`.
- `in_ready` = (`count` != DEPTH). It depends only on state, never on `out_ready`. There is no write-through when full.
- `out_valid` = (`count` != 0).
- On push, `in_rec` is written to `mem[wr_ptr]` and `wr_ptr` increments.
- On pop, `rd_ptr` increments.
- Pointers are `$clog2(DEPTH)` bits wide and wrap naturally from DEPTH-1 to 0.
- `count` update:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on simultaneous push and pop, including when `count`=1.
- `out_rec` is combinational from `mem[rd_ptr]`, transformed as follows:
  - SWAP=1: `out.ps.a` = `mem.ps.b` and `out.ps.b` = `mem.ps.a`.
  - FILL_T=1: `out.t` = 8'h55.
  - Fields `a` and `b` are always passed unchanged.
- When `out_valid`=0, `out_rec` is driven to all zeros.
- `overflow` is set by any cycle with `in_valid & ~in_ready` and cleared only by reset. A refused record is dropped without corrupting state.
- Reset (`rst_n`=0 at an edge):
  - pointers, `count` and `overflow` go to 0.
  - `out_valid` goes to 0 and `out_rec` to '0.
  - `in_ready` goes to 1.
  - memory contents are not cleared.
  - A reset in the middle of a burst discards all held records. A push in the same cycle as reset is ignored.

## Timing
- Latency: a record pushed at edge N is visible on `out_valid`/`out_rec` after edge N (first word fall-through, 1 cycle).
- Throughput: one push and one pop per cycle sustained. At full occupancy with `out_ready`=1, `in_ready` stays 0 in that cycle and rises after the pop edge.
- `in_ready`, `out_valid` and `count` are registered-state decodes. None has a combinational path from `in_valid` or `out_ready`.
- Empty with `in_valid`=1 and `out_ready`=1: only the push takes effect. `count` becomes 1 and the pop happens no earlier than the next cycle.

## Structure
- Package `rec_pkg`:
  - `byte_t` = logic[7:0].
  - `pair_t` = packed struct {byte a; byte b}.
  - `rec_t` = packed struct {bit a; logic[7:0] b; byte_t t; pair_t ps}, MSB first.
  - `REC_W` = 33.
  - `SWAP_NONE`/`SWAP_PS` constants.
- Sub-module `rec_fifo_mem`: DEPTH x REC_W storage with a synchronous write port and an asynchronous read port. It stores raw `logic[REC_W-1:0]`; casting to and from `rec_t` happens in `rec_fifo`.
- `rec_fifo` holds the pointers, the count, the flags and the output transform.

## Test plan
- Reset, then idle: `count`=0, `out_valid`=0, `in_ready`=1, `overflow`=0, `out_rec`=33'h0.
- Push the record {a=1, b=8'hFF, t=8'h55, ps={8'hAA, 8'h55}} with SWAP=0 -> the next cycle shows `out_valid`=1 and `out_rec` equal to the input; after a pop, `count`=0.
- SWAP=1, FILL_T=1, push {a=1, b=8'h12, t=8'h00, ps={8'hAA, 8'h55}} -> output {1, 8'h12, 8'h55, {8'h55, 8'hAA}}.
- DEPTH=4: push 5 records with `b`=1..5 and `out_ready`=0 -> `count`=4, `in_ready`=0, `overflow`=1; draining yields `b`=1,2,3,4 in order.
- Hold `in_valid`=`out_ready`=1 for 20 cycles from `count`=2 with incrementing `b` -> `count` stays 2, output order is preserved, and the pointers wrap five times with no loss.
- Assert `rst_n`=0 for one cycle at `count`=3 -> the next cycle shows `count`=0, `out_valid`=0, `overflow`=0, and the following push is the next output.
